multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Multi-cycle control FSM sitting directly upstream of the datapath/instruction-setter pair. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It drives the datapath control inputs (writeEnable_Registers, writeEnable_DataMemory, muxSelect_SumVsReadData, muxSelect_ImmVsDataout2, SumOrSub) plus PC and instruction-register enables. It consumes selectedFlag from the datapath to resolve branches.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = keep executing, 0 = stop at next instruction boundary
instruction  input  32  current instruction from the instruction register; stable from DECODE until instruction completion
selectedFlag  input  1  branch-condition result from the datapath, valid in EXECUTE
irLoad  output  1  load instruction register (fetch strobe)
pcWrite  output  1  update PC this cycle
pcSrc  output  1  1 = PC+imm (taken branch), 0 = PC+4; meaningful only when pcWrite=1
writeEnable_Registers  output  1  register-file write enable
writeEnable_DataMemory  output  1  data-memory write enable
muxSelect_SumVsReadData  output  1  1 = write-back from memory read data, 0 = from adder
muxSelect_ImmVsDataout2  output  1  1 = immediate, 0 = dataout2
SumOrSub  output  1  1 = subtract, 0 = add
busy  output  1  1 in any state except IDLE and HALT
retire  output  1  one-cycle pulse on the last cycle of each completed instruction
retiredCount  output  CNT_WIDTH  number of retired instructions, wraps modulo 2^CNT_WIDTH
illegalInstruction  output  1  sticky; set on an unsupported opcode

Behaviour:
- Reset (async, reset_n=0): state=IDLE, class register cleared, retiredCount=0, illegalInstruction=0. All other outputs 0 immediately. Reset takes effect mid-instruction with no partial write.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- Outputs are decoded from registered state and latched class only. Exception: pcSrc = selectedFlag while in EXECUTE for BRANCH.
- Supported opcodes (instruction[6:0]):
  - 0110011 R-type: add/sub, funct3=000. SumOrSub = instruction[30].
  - 0010011 addi
  - 0000011 ld
  - 0100011 sd
  - 1100011 branch: funct3 is passed through to the datapath; this block uses only selectedFlag.
- Any other opcode, or R-type with funct3≠000, is ILLEGAL.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: irLoad=1 → DECODE.
- DECODE: classify the opcode and latch class + sub bit.
  - ILLEGAL → HALT.
  - Otherwise → EXECUTE.
- EXECUTE:
  - muxSelect_ImmVsDataout2=1 for addi/ld/sd, 0 for R/branch.
  - SumOrSub = latched sub bit for R, 1 for branch, 0 otherwise.
  - These two ALU controls hold their value from EXECUTE until the instruction completes.
  - BRANCH: pcWrite=1, pcSrc=selectedFlag, retire=1; instruction ends here.
  - R/addi → WRITEBACK; ld/sd → MEMORY.
- MEMORY:
  - sd: writeEnable_DataMemory=1, pcWrite=1 (pcSrc=0), retire=1; instruction ends.
  - ld → WRITEBACK.
- WRITEBACK: writeEnable_Registers=1, muxSelect_SumVsReadData=1 for ld (else 0), pcWrite=1 (pcSrc=0), retire=1; instruction ends.
- Instruction end: next state is FETCH if run=1, else IDLE. run is sampled only in IDLE and at instruction end; deasserting it mid-instruction never aborts.
- Latency FETCH→retire: branch 3 cycles, R/addi/sd 4 cycles, ld 5 cycles.
- Each write enable is high for exactly one cycle per instruction.
- retiredCount increments on the retire cycle and wraps from all-ones to 0.
- HALT:
  - illegalInstruction set and sticky; busy=0.
  - No enable is asserted; pcWrite=0, so the PC remains at the illegal instruction.
  - run is ignored; only reset exits HALT.

Decomposition:
- Shared include controlDefs.vh holds: state encodings (3-bit), opcode constants, instruction-class encodings (R, ADDI, LD, SD, BRANCH, ILLEGAL).
- One combinational sub-module, opcode_classifier: inputs instruction[6:0], funct3, instruction[30]; outputs class and sub bit. Instantiated in DECODE logic.
- The FSM, output decode and counter stay in multicycle_control.

Test Plan:
- Reset release, run=1, instruction=0x00208033 (add x0,x1,x2) → irLoad in cycle 1; writeEnable_Registers=1 only in cycle 4 with SumOrSub=0, muxSelect_ImmVsDataout2=0, muxSelect_SumVsReadData=0; retiredCount=1.
- instruction=0x40208033 (sub) → SumOrSub=1 in EXECUTE and WRITEBACK; instruction=0x0000B003 (ld) → writeEnable_Registers in cycle 5 with muxSelect_SumVsReadData=1, muxSelect_ImmVsDataout2=1.
- instruction=0x0020B023 (sd) → writeEnable_DataMemory=1 exactly in cycle 4, writeEnable_Registers never asserted; beq 0x00208463 with selectedFlag=1 → cycle 3 pcWrite=1, pcSrc=1; with selectedFlag=0 → pcSrc=0.
- run dropped during EXECUTE of an add → instruction completes, retire pulses, state goes to IDLE, busy=0; run reasserted → FETCH next cycle.
- instruction=0xFFFFFFFF → HALT after DECODE, illegalInstruction=1, all enables stay 0 for 20 cycles with run=1; reset_n low → illegalInstruction=0.
- reset_n asserted asynchronously mid-WRITEBACK → writeEnable_Registers drops before the next clock edge; retiredCount=0. Force retiredCount to all-ones → next retire wraps it to 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle control FSM.
// Covers state and instruction-class encodings plus the opcodes this control path supports.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R       = 3'd0,
    C_ADDI    = 3'd1,
    C_LD      = 3'd2,
    C_SD      = 3'd3,
    C_BRANCH  = 3'd4,
    C_ILLEGAL = 3'd5
  } iclass_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_SD     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/multicycle_control_opcode_classifier.sv
// Combinational opcode decoder.
// Maps opcode, funct3 and instruction bit 30 to an instruction class and a subtract flag.
module opcode_classifier
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output iclass_t    iclass,
  output logic       sub
);

  always_comb begin
    iclass = C_ILLEGAL;
    sub    = 1'b0;
    case (opcode)
      OP_R: begin
        // Only add/sub are implemented; other R-type functions trap.
        if (funct3 == 3'b000) begin
          iclass = C_R;
          sub    = bit30;
        end
      end
      OP_ADDI:   iclass = C_ADDI;
      OP_LD:     iclass = C_LD;
      OP_SD:     iclass = C_SD;
      OP_BRANCH: iclass = C_BRANCH;
      default:   iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer driving datapath controls.
// Outputs are decoded from the registered state and the class latched in DECODE.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [31:0]          instruction,
  input  logic                 selectedFlag,
  output logic                 irLoad,
  output logic                 pcWrite,
  output logic                 pcSrc,
  output logic                 writeEnable_Registers,
  output logic                 writeEnable_DataMemory,
  output logic                 muxSelect_SumVsReadData,
  output logic                 muxSelect_ImmVsDataout2,
  output logic                 SumOrSub,
  output logic                 busy,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] retiredCount,
  output logic                 illegalInstruction
);

  state_t  state;
  iclass_t cls;
  logic    sub_bit;
  iclass_t dec_class;
  logic    dec_sub;
  state_t  end_state;
  logic    in_alu;
  logic    unused_bits;

  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  opcode_classifier u_classifier (
    .opcode (instruction[6:0]),
    .funct3 (instruction[14:12]),
    .bit30  (instruction[30]),
    .iclass (dec_class),
    .sub    (dec_sub)
  );

  assign end_state = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      cls                <= C_R;
      sub_bit            <= 1'b0;
      retiredCount       <= '0;
      illegalInstruction <= 1'b0;
    end else begin
      if (retire)
        retiredCount <= retiredCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      case (state)
        S_IDLE:   if (run) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          cls     <= dec_class;
          sub_bit <= dec_sub;
          if (dec_class == C_ILLEGAL) begin
            state              <= S_HALT;
            illegalInstruction <= 1'b1;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (cls)
            C_BRANCH:   state <= end_state;
            C_LD, C_SD: state <= S_MEMORY;
            default:    state <= S_WRITEBACK;
          endcase
        end
        S_MEMORY:    state <= (cls == C_SD) ? end_state : S_WRITEBACK;
        S_WRITEBACK: state <= end_state;
        S_HALT:      state <= S_HALT;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // ALU controls stay valid from EXECUTE through the final cycle of the instruction.
  assign in_alu = (state == S_EXECUTE) || (state == S_MEMORY) || (state == S_WRITEBACK);

  assign irLoad                  = (state == S_FETCH);
  assign muxSelect_ImmVsDataout2 = in_alu && ((cls == C_ADDI) || (cls == C_LD) || (cls == C_SD));
  assign SumOrSub                = in_alu && ((cls == C_R) ? sub_bit : (cls == C_BRANCH));
  assign writeEnable_Registers   = (state == S_WRITEBACK);
  assign writeEnable_DataMemory  = (state == S_MEMORY) && (cls == C_SD);
  assign muxSelect_SumVsReadData = (state == S_WRITEBACK) && (cls == C_LD);
  assign pcWrite                 = ((state == S_EXECUTE) && (cls == C_BRANCH)) ||
                                   ((state == S_MEMORY) && (cls == C_SD)) ||
                                   (state == S_WRITEBACK);
  assign pcSrc                   = (state == S_EXECUTE) && (cls == C_BRANCH) && selectedFlag;
  assign retire                  = pcWrite;
  assign busy                    = (state != S_IDLE) && (state != S_HALT);

endmodule
